// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/stall controller.
package hazard_pkg;

    // Execute-stage operand mux selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Multi-cycle multiply sequencer states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

endpackage

// File: rtl/mul_stall_timer.sv
// Holds a multiply in Execute for MUL_CYCLES cycles: stalls for the first
// MUL_CYCLES-1 cycles and flags the result on the last one.
module mul_stall_timer
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = 4
)
(
    input  logic clk,
    input  logic reset,
    input  logic MulE,
    output logic MulStall,
    output logic MulDoneE
);

    // Counter must hold MUL_CYCLES-2; keep at least one bit for tiny latencies
    localparam int            CW       = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);

    mul_state_t    state;
    logic [CW-1:0] cnt;

    // Sequencer state and residency down-counter; reset aborts any multiply in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MulE && (MUL_CYCLES > 1)) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall while residency remains; the final cycle releases the stall and marks done
    always_comb begin
        MulStall = 1'b0;
        MulDoneE = 1'b0;
        case (state)
            IDLE: begin
                if (MulE) begin
                    if (MUL_CYCLES > 1) MulStall = 1'b1;
                    else                MulDoneE = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != '0) MulStall = 1'b1;
                else           MulDoneE = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the F/D/E/M/W pipeline: operand forwarding,
// load-use interlock, branch flushes, multiply stalls and a stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REGW       = 4,
    parameter int ZERO_REG   = 0,
    parameter int MUL_CYCLES = 4,
    parameter int CNTW       = 16
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] Ra1D,
    input  logic [REGW-1:0] Ra2D,
    input  logic [REGW-1:0] Ra1E,
    input  logic [REGW-1:0] Ra2E,
    input  logic [REGW-1:0] WA3E,
    input  logic [REGW-1:0] WA3M,
    input  logic [REGW-1:0] WA3W,
    input  logic            RegWriteE,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic            MemtoRegE,
    input  logic            BranchTakenE,
    input  logic            MulE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            FlushD,
    output logic            FlushE,
    output logic            FlushM,
    output logic            MulDoneE,
    output logic [CNTW-1:0] StallCount
);

    logic LdStall;
    logic MulStall;
    logic ld_src_ok;

    // Hardwired-zero register never carries a real result
    function automatic logic is_zero_reg(input logic [REGW-1:0] ra);
        return (ZERO_REG != 0) && (ra == '0);
    endfunction

    // Newest producer wins: M ahead of W
    function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] ra);
        if (RegWriteM && (WA3M == ra) && !is_zero_reg(ra))      return FWD_MEM;
        else if (RegWriteW && (WA3W == ra) && !is_zero_reg(ra)) return FWD_WB;
        else                                                    return FWD_RF;
    endfunction

    // Counter increment that pins at all-ones
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == '1) ? v : v + CNTW'(1);
    endfunction

    mul_stall_timer #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .MulE     (MulE),
        .MulStall (MulStall),
        .MulDoneE (MulDoneE)
    );

    // Forwarding selects and load-use detection
    always_comb begin
        ForwardAE = fwd_sel(Ra1E);
        ForwardBE = fwd_sel(Ra2E);
        ld_src_ok = MemtoRegE && RegWriteE && !is_zero_reg(WA3E);
        LdStall   = ld_src_ok && ((Ra1D == WA3E) || (Ra2D == WA3E));
    end

    // Pipeline enables/clears; a held E stage is never flushed
    always_comb begin
        StallF = LdStall | MulStall;
        StallD = LdStall | MulStall;
        StallE = MulStall;
        FlushM = MulStall;
        FlushD = BranchTakenE & ~MulStall;
        FlushE = (LdStall | BranchTakenE) & ~MulStall;
    end

    // Saturating count of fetch-stall cycles
    always_ff @(posedge clk) begin
        if (reset)       StallCount <= '0;
        else if (StallF) StallCount <= sat_inc(StallCount);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (zero-register variant with a 4-bit
// counter, default variant with a 16-bit counter) checked against a reference model.
module tb_hazard_ctrl;

    localparam int MULC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MulE;

    logic [1:0]  fa, fb, fa0, fb0;
    logic        sf, sd, se, fd, fe, fm, md;
    logic        sf0, sd0, se0, fd0, fe0, fm0, md0;
    logic [3:0]  sc4;
    logic [15:0] sc16;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  fa, fb, fa0, fb0;
        logic        sf, sd, se, fd, fe, fm, md, sf0;
        logic [3:0]  sc4;
        logic [15:0] sc16;
    } obs_t;

    obs_t sb[$];
    obs_t last_obs;

    int mul_left, m_cnt4, m_cnt16;

    hazard_ctrl #(.REGW(4), .ZERO_REG(1), .MUL_CYCLES(MULC), .CNTW(4)) dut (
        .clk(clk), .reset(reset), .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .MulE(MulE),
        .ForwardAE(fa), .ForwardBE(fb), .StallF(sf), .StallD(sd), .StallE(se),
        .FlushD(fd), .FlushE(fe), .FlushM(fm), .MulDoneE(md), .StallCount(sc4)
    );

    hazard_ctrl #(.REGW(4), .ZERO_REG(0), .MUL_CYCLES(MULC), .CNTW(16)) dut0 (
        .clk(clk), .reset(reset), .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE), .MulE(MulE),
        .ForwardAE(fa0), .ForwardBE(fb0), .StallF(sf0), .StallD(sd0), .StallE(se0),
        .FlushD(fd0), .FlushE(fe0), .FlushM(fm0), .MulDoneE(md0), .StallCount(sc16)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_fwd(input int zr, input logic [3:0] ra);
        if (zr != 0 && ra == 4'd0)        return 2'b00;
        if (RegWriteM && WA3M == ra)      return 2'b10;
        if (RegWriteW && WA3W == ra)      return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_ld(input int zr);
        if (!(MemtoRegE && RegWriteE)) return 1'b0;
        if (zr != 0 && WA3E == 4'd0)   return 1'b0;
        return (Ra1D == WA3E) || (Ra2D == WA3E);
    endfunction

    // One clock: model expectation pushed, DUT sampled on the falling edge, compared
    task automatic cycle();
        obs_t e, o;
        logic mstall, mdone, ld1, ld0;
        mstall = (mul_left == 0) ? (MulE && MULC > 1) : (mul_left > 1);
        mdone  = (mul_left == 0) ? (MulE && MULC == 1) : (mul_left == 1);
        ld1    = m_ld(1);
        ld0    = m_ld(0);
        e.fa   = m_fwd(1, Ra1E);
        e.fb   = m_fwd(1, Ra2E);
        e.fa0  = m_fwd(0, Ra1E);
        e.fb0  = m_fwd(0, Ra2E);
        e.sf   = ld1 | mstall;
        e.sd   = ld1 | mstall;
        e.se   = mstall;
        e.fm   = mstall;
        e.fd   = mstall ? 1'b0 : BranchTakenE;
        e.fe   = mstall ? 1'b0 : (ld1 | BranchTakenE);
        e.md   = mdone;
        e.sf0  = ld0 | mstall;
        e.sc4  = 4'(m_cnt4);
        e.sc16 = 16'(m_cnt16);
        sb.push_back(e);
        @(negedge clk);
        o.fa = fa; o.fb = fb; o.fa0 = fa0; o.fb0 = fb0;
        o.sf = sf; o.sd = sd; o.se = se; o.fd = fd; o.fe = fe; o.fm = fm; o.md = md;
        o.sf0 = sf0; o.sc4 = sc4; o.sc16 = sc16;
        last_obs = o;
        e = sb.pop_front();
        check("ForwardAE", 32'(o.fa), 32'(e.fa));
        check("ForwardBE", 32'(o.fb), 32'(e.fb));
        check("ForwardAE_zr0", 32'(o.fa0), 32'(e.fa0));
        check("ForwardBE_zr0", 32'(o.fb0), 32'(e.fb0));
        check("StallF", 32'(o.sf), 32'(e.sf));
        check("StallD", 32'(o.sd), 32'(e.sd));
        check("StallE", 32'(o.se), 32'(e.se));
        check("FlushD", 32'(o.fd), 32'(e.fd));
        check("FlushE", 32'(o.fe), 32'(e.fe));
        check("FlushM", 32'(o.fm), 32'(e.fm));
        check("MulDoneE", 32'(o.md), 32'(e.md));
        check("StallF_zr0", 32'(o.sf0), 32'(e.sf0));
        check("StallCount4", 32'(o.sc4), 32'(e.sc4));
        check("StallCount16", 32'(o.sc16), 32'(e.sc16));
        @(posedge clk);
        if (reset) begin
            mul_left = 0; m_cnt4 = 0; m_cnt16 = 0;
        end else begin
            if (mul_left == 0) mul_left = (MulE && MULC > 1) ? MULC - 1 : 0;
            else               mul_left = mul_left - 1;
            if (e.sf  && m_cnt4  < 15)    m_cnt4++;
            if (e.sf0 && m_cnt16 < 65535) m_cnt16++;
        end
        #1;
    endtask

    task automatic clear_inputs();
        {Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MulE} = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        mul_left = 0; m_cnt4 = 0; m_cnt16 = 0;
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        // Reset state
        cycle();
        check("rst_StallCount", 32'(last_obs.sc4), 32'd0);
        check("rst_MulDoneE", 32'(last_obs.md), 32'd0);
        reset = 1'b0;

        // Forwarding priority
        RegWriteM = 1; RegWriteW = 1; WA3M = 5; WA3W = 5; Ra1E = 5; Ra2E = 5;
        cycle();
        check("tp_fwdA_mem", 32'(last_obs.fa), 32'd2);
        RegWriteM = 0;
        cycle();
        check("tp_fwdA_wb", 32'(last_obs.fa), 32'd1);
        RegWriteM = 1; WA3M = 0; Ra1E = 0;
        cycle();
        check("tp_fwdA_zero", 32'(last_obs.fa), 32'd0);
        check("tp_fwdA_zero_zr0", 32'(last_obs.fa0), 32'd2);

        // Mixed random forwarding/load/branch traffic over a small register range
        for (int i = 0; i < 24; i++) begin
            Ra1D = 4'($urandom_range(0, 3)); Ra2D = 4'($urandom_range(0, 3));
            Ra1E = 4'($urandom_range(0, 3)); Ra2E = 4'($urandom_range(0, 3));
            WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
            WA3W = 4'($urandom_range(0, 3));
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            MemtoRegE = 1'($urandom); BranchTakenE = 1'($urandom_range(0, 3) == 0);
            cycle();
        end

        // Load-use for exactly one cycle
        do_reset();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 3; Ra2D = 3; Ra1D = 1;
        cycle();
        check("tp_ld_StallF", 32'(last_obs.sf), 32'd1);
        check("tp_ld_FlushE", 32'(last_obs.fe), 32'd1);
        check("tp_ld_FlushD", 32'(last_obs.fd), 32'd0);
        MemtoRegE = 0;
        cycle();
        check("tp_ld_release", 32'(last_obs.sf), 32'd0);
        check("tp_ld_count", 32'(last_obs.sc4), 32'd1);

        // Two back-to-back multiplies
        do_reset();
        MulE = 1;
        for (int i = 0; i < 2 * MULC; i++) begin
            cycle();
            check("tp_mul_StallE", 32'(last_obs.se), 32'((i % MULC) != MULC - 1));
            check("tp_mul_Done", 32'(last_obs.md), 32'((i % MULC) == MULC - 1));
        end
        MulE = 0;
        cycle();
        check("tp_mul_count", 32'(last_obs.sc4), 32'd6);

        // Branch alone, branch with load-use, branch under multiply
        do_reset();
        BranchTakenE = 1;
        cycle();
        check("tp_br_FlushD", 32'(last_obs.fd), 32'd1);
        check("tp_br_StallF", 32'(last_obs.sf), 32'd0);
        MemtoRegE = 1; RegWriteE = 1; WA3E = 2; Ra1D = 2;
        cycle();
        check("tp_brld_FlushE", 32'(last_obs.fe), 32'd1);
        check("tp_brld_StallF", 32'(last_obs.sf), 32'd1);
        MemtoRegE = 0; MulE = 1;
        cycle();
        check("tp_brmul_FlushE", 32'(last_obs.fe), 32'd0);
        MulE = 0; BranchTakenE = 0;
        for (int i = 0; i < MULC; i++) cycle();

        // Reset during the second cycle of a multiply
        do_reset();
        MulE = 1;
        cycle();
        MulE = 0; reset = 1;
        cycle();
        reset = 0;
        cycle();
        check("tp_rstmul_StallE", 32'(last_obs.se), 32'd0);
        check("tp_rstmul_Done", 32'(last_obs.md), 32'd0);
        check("tp_rstmul_count", 32'(last_obs.sc4), 32'd0);
        for (int i = 0; i < MULC; i++) cycle();

        // Counter saturation with a held load-use stall
        do_reset();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 7; Ra1D = 7;
        for (int i = 0; i < 20; i++) cycle();
        check("tp_sat_count4", 32'(last_obs.sc4), 32'd15);
        check("tp_sat_count16", 32'(last_obs.sc16), 32'd19);
        cycle();
        check("tp_sat_hold", 32'(last_obs.sc4), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
